// File: rtl/alu_op_sequencer.sv
// Drives the ALU's ra/rb/inst inputs for one request at a time and returns the result.
// It also runs an 8x8 unsigned multiply as four 4x4 ALU multiplies summed into a 16-bit product.
module alu_op_sequencer #(
  parameter logic [3:0] MUL8_OP   = 4'b0110,
  parameter logic [7:0] IDLE_INST = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_op,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  output logic [7:0] alu_ra,
  output logic [7:0] alu_rb,
  output logic [7:0] alu_inst,
  input  logic [7:0] alu_rd,
  input  logic [7:0] alu_flags,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic [7:0] resp_lo,
  output logic [7:0] resp_hi,
  output logic [7:0] resp_flags,
  output logic       resp_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_EXEC, S_FLAG, S_MUL0, S_MUL1, S_MUL2, S_MUL3, S_DONE
  } state_e;

  state_e      state_q;
  logic [7:0]  a_q, b_q;
  logic [15:0] acc_q, acc_d;
  logic [7:0]  alu_ra_q, alu_rb_q, alu_inst_q;
  logic [7:0]  resp_lo_q, resp_hi_q, resp_flags_q;
  logic        resp_err_q;

  // Place the current partial product at its nibble weight: lo*lo=0, cross terms=4, hi*hi=8.
  function automatic logic [15:0] mul_term(input state_e st, input logic [7:0] rd);
    logic [15:0] ext;
    ext = {8'h00, rd};
    case (st)
      S_MUL1, S_MUL2: mul_term = ext << 4;
      S_MUL3:         mul_term = ext << 8;
      default:        mul_term = ext;
    endcase
  endfunction

  assign acc_d = acc_q + mul_term(state_q, alu_rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      a_q          <= 8'h00;
      b_q          <= 8'h00;
      acc_q        <= 16'h0000;
      alu_ra_q     <= 8'h00;
      alu_rb_q     <= 8'h00;
      alu_inst_q   <= IDLE_INST;
      resp_lo_q    <= 8'h00;
      resp_hi_q    <= 8'h00;
      resp_flags_q <= 8'h00;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            a_q   <= req_a;
            b_q   <= req_b;
            acc_q <= 16'h0000;
            case (req_op[7:4])
              4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b0100, 4'b0101: begin
                state_q    <= S_EXEC;
                alu_inst_q <= req_op;
                alu_ra_q   <= req_a;
                alu_rb_q   <= req_b;
              end
              MUL8_OP: begin
                state_q    <= S_MUL0;
                alu_inst_q <= {4'b0100, req_op[3:0]};
                alu_ra_q   <= {4'h0, req_a[3:0]};
                alu_rb_q   <= {4'h0, req_b[3:0]};
              end
              default: begin
                state_q      <= S_DONE;
                resp_lo_q    <= 8'h00;
                resp_hi_q    <= 8'h00;
                resp_flags_q <= 8'h00;
                resp_err_q   <= 1'b1;
              end
            endcase
          end
        end
        S_EXEC: begin
          resp_lo_q  <= alu_rd;
          resp_hi_q  <= 8'h00;
          resp_err_q <= 1'b0;
          state_q    <= S_FLAG;
        end
        // Inputs are held here so the ALU flag register reloads the same value we sample.
        S_FLAG: begin
          resp_flags_q <= alu_flags;
          alu_inst_q   <= IDLE_INST;
          alu_ra_q     <= 8'h00;
          alu_rb_q     <= 8'h00;
          state_q      <= S_DONE;
        end
        S_MUL0: begin
          acc_q    <= acc_d;
          alu_ra_q <= {4'h0, a_q[7:4]};
          alu_rb_q <= {4'h0, b_q[3:0]};
          state_q  <= S_MUL1;
        end
        S_MUL1: begin
          acc_q    <= acc_d;
          alu_ra_q <= {4'h0, a_q[3:0]};
          alu_rb_q <= {4'h0, b_q[7:4]};
          state_q  <= S_MUL2;
        end
        S_MUL2: begin
          acc_q    <= acc_d;
          alu_ra_q <= {4'h0, a_q[7:4]};
          alu_rb_q <= {4'h0, b_q[7:4]};
          state_q  <= S_MUL3;
        end
        S_MUL3: begin
          acc_q        <= acc_d;
          {resp_hi_q, resp_lo_q} <= acc_d;
          resp_flags_q <= (acc_d == 16'h0000) ? 8'h01 : 8'h00;
          resp_err_q   <= 1'b0;
          alu_inst_q   <= IDLE_INST;
          alu_ra_q     <= 8'h00;
          alu_rb_q     <= 8'h00;
          state_q      <= S_DONE;
        end
        S_DONE: begin
          if (resp_ready) state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = rst_n & (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign resp_valid = (state_q == S_DONE);
  assign alu_ra     = alu_ra_q;
  assign alu_rb     = alu_rb_q;
  assign alu_inst   = alu_inst_q;
  assign resp_lo    = resp_lo_q;
  assign resp_hi    = resp_hi_q;
  assign resp_flags = resp_flags_q;
  assign resp_err   = resp_err_q;

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Sits between the instruction decode/control path and the ArithmeticLogicUnit, and owns the ALU's ra/rb/inst inputs.
- Accepts one ALU request at a time over a valid/ready handshake and sequences the ALU for the required number of cycles.
- Captures the result and flags, and returns a response over a valid/ready handshake.
- Adds an extended 8x8 unsigned multiply (MUL8). MUL8 runs four 4x4 partial products through the ALU's 4-bit multiplier and accumulates them internally into a 16-bit product.

Parameters:
- MUL8_OP, 4'b0110, inst[7:4] code for the extended 8x8 unsigned multiply.
- IDLE_INST, 8'h00, value driven on alu_inst when no operation is in flight (ALU default: rd=0, flags=0).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_op  in  8  instruction byte; inst[7:4] selects the operation.
- req_a  in  8  operand A.
- req_b  in  8  operand B.
- alu_ra  out  8  to ALU ra.
- alu_rb  out  8  to ALU rb.
- alu_inst  out  8  to ALU inst.
- alu_rd  in  8  from ALU rd (combinational).
- alu_flags  in  8  from ALU flags (registered in the ALU on clk).
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_lo  out  8  result low byte.
- resp_hi  out  8  result high byte; 0 for all non-MUL8 ops.
- resp_flags  out  8  flags for the response.
- resp_err  out  1  unsupported opcode.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE; any in-flight request is dropped.
  - resp_valid=0, busy=0, resp_lo/hi/flags=0, resp_err=0.
  - Internal latches and accumulator clear to 0.
  - alu_inst=IDLE_INST, alu_ra=alu_rb=0.
  - req_ready=1 when rst_n=1 and state is IDLE.
- States: IDLE, EXEC, FLAG, MUL0, MUL1, MUL2, MUL3, DONE.
- IDLE:
  - req_ready=1. The handshake is req_valid&req_ready; on it, latch req_op, req_a and req_b.
  - Next state is decoded from op[7:4]:
    - 1000/1001/1010/1011/0100/0101 go to EXEC.
    - MUL8_OP goes to MUL0.
    - Any other code goes to DONE with resp_lo=resp_hi=resp_flags=0 and resp_err=1.
- Outside IDLE: req_ready=0; there is no queuing.
- EXEC:
  - Drive alu_inst=op, alu_ra=a, alu_rb=b.
  - On the edge, capture resp_lo=alu_rd, resp_hi=0, resp_err=0; the ALU latches its flags on the same edge. Go to FLAG.
- FLAG:
  - Hold the same alu_inst/ra/rb, so the ALU's flag register reloads an identical value.
  - On the edge, capture resp_flags=alu_flags. Go to DONE.
- MUL0..MUL3:
  - alu_inst={4'b0100,op[3:0]}.
  - Operand nibbles, zero-extended to 8 bits:
    - MUL0: a[3:0] x b[3:0], accumulated with shift 0.
    - MUL1: a[7:4] x b[3:0], shift 4.
    - MUL2: a[3:0] x b[7:4], shift 4.
    - MUL3: a[7:4] x b[7:4], shift 8.
  - Each edge does acc <= acc + (alu_rd << shift), in 16 bits with no overflow possible. acc clears to 0 on acceptance.
  - After MUL3: {resp_hi,resp_lo}=final acc, resp_flags=8'h01 if the product is 0 else 8'h00, resp_err=0. Go to DONE.
  - ALU flags produced during MUL8 are ignored.
- DONE:
  - resp_valid=1. alu_inst=IDLE_INST, alu_ra=alu_rb=0.
  - resp_* are held stable while resp_ready=0.
  - On resp_valid&resp_ready, go to IDLE. resp_* keep their values until the next response overwrites them.
- Latency (acceptance edge in cycle n): resp_valid first high in
  - cycle n+3 for single ops;
  - cycle n+5 for MUL8;
  - cycle n+1 for unsupported opcodes.
- Throughput: no same-cycle re-acceptance. req_ready returns the cycle after the response handshake. Minimum request spacing is 4, 6 or 2 cycles respectively.
- Driving rule: in IDLE and DONE alu_inst=IDLE_INST; it is never left floating.
- Input stability: req_* changing after acceptance has no effect.
- Reset mid-operation: any state goes to IDLE immediately. No response is produced for the dropped request.

Test Plan:
- ADD: req_op=8'hA0, a=8'h05, b=8'h03 accepted cycle n -> resp_valid at n+3, resp_lo=8'h08, resp_hi=0, resp_err=0, resp_flags equals alu_flags sampled in the FLAG cycle; alu_inst=8'hA0 during n+1..n+2.
- MUL8: req_op=8'h60, a=8'hFF, b=8'hFF -> partial products E1,E1,E1,E1 observed on alu_rd; at n+5 {resp_hi,resp_lo}=16'hFE01, resp_flags=8'h00. Second case a=8'h12, b=8'h34 -> 16'h03A8.
- MUL8 zero: a=8'h00, b=8'h37 -> 16'h0000, resp_flags=8'h01.
- Unsupported: req_op=8'h30 -> resp_valid at n+1, resp_err=1, resp_lo=resp_hi=resp_flags=0; alu_inst stays 8'h00 throughout.
- Backpressure: hold resp_ready=0 for 5 cycles in DONE with req_valid=1 -> resp_* stable, req_ready=0, busy=1. Raise resp_ready -> req_ready=1 the next cycle, and the next request is accepted.
- Reset mid-op: assert rst_n=0 during MUL2 -> immediately resp_valid=0, busy=0, resp_*=0, alu_inst=8'h00. After release, a new ADD completes normally with no stale response.
